machine_timer_unit: RTL and testbench

- Memory-mapped RISC-V machine timer: 64-bit mtime counter, 64-bit mtimecmp compare register, and a registered timer-interrupt request.
- Sits directly upstream of the CSR unit: reqTimerInterrupt drives the CSR unit's timer request input, which becomes mip.MTIP.
- Registers are accessed as 32-bit words from the IO/memory-mapped path. Read data is returned one cycle after the read request.

---
 rtl/machine_timer_unit.sv | 130 +++++++++++++
 tb/tb_machine_timer_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module   : machine_timer_unit
//  Purpose  : Memory-mapped RISC-V machine timer. Holds a 64-bit mtime
//             counter advanced by a prescaler, a 64-bit mtimecmp compare
//             register and a registered level timer-interrupt request that
//             feeds the CSR unit (mip.MTIP). Registers are accessed as
//             32-bit words; read data returns one cycle after the request.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             wrEn, rdEn          - write / read strobes
//             regAddr[1:0]        - 0 MTIME_LO, 1 MTIME_HI,
//                                   2 MTIMECMP_LO, 3 MTIMECMP_HI
//             wrData[31:0]        - write data
//             rdData[31:0]        - read data, valid while rdValid = 1
//             rdValid             - pulses the cycle after an accepted rdEn
//             reqTimerInterrupt   - level request, mtime >= mtimecmp
//             mtimeOut[63:0]      - live mtime register for debug/trace
//  Revision : 1.0 - initial release
// ============================================================================
module machine_timer_unit #(
   parameter int PRESCALE_DIV = 1,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wrEn,
   input  logic                  rdEn,
   input  logic [1:0]            regAddr,
   input  logic [DATA_WIDTH-1:0] wrData,
   output logic [DATA_WIDTH-1:0] rdData,
   output logic                  rdValid,
   output logic                  reqTimerInterrupt,
   output logic [63:0]           mtimeOut
);

   localparam logic [1:0] ADDR_MTIME_LO    = 2'd0;
   localparam logic [1:0] ADDR_MTIME_HI    = 2'd1;
   localparam logic [1:0] ADDR_MTIMECMP_LO = 2'd2;
   localparam logic [1:0] ADDR_MTIMECMP_HI = 2'd3;

   // A divide-by-one prescaler still needs a one-bit counter that never moves.
   localparam int CNT_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

   logic [CNT_W-1:0] presc_count;
   logic             tick;
   logic [63:0]      mtime;
   logic [63:0]      mtimecmp;
   logic [31:0]      shadow_hi;

   assign tick     = (presc_count == CNT_W'(PRESCALE_DIV - 1));
   assign mtimeOut = mtime;

   always_ff @(posedge clk) begin
      assert (PRESCALE_DIV >= 1)
         else $error("machine_timer_unit: PRESCALE_DIV must be >= 1");
   end

   // Prescaler: free-running, unaffected by writes to mtime.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_count <= '0;
      end else if (tick) begin
         presc_count <= '0;
      end else begin
         presc_count <= presc_count + CNT_W'(1);
      end
   end

   // mtime: a software write to either half replaces the whole register
   // update for that cycle, so the untouched half keeps its old value and
   // the pending increment (and any carry) is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime <= 64'd0;
      end else if (wrEn && (regAddr == ADDR_MTIME_LO)) begin
         mtime <= {mtime[63:32], wrData};
      end else if (wrEn && (regAddr == ADDR_MTIME_HI)) begin
         mtime <= {wrData, mtime[31:0]};
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // mtimecmp: only ever changed by software writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtimecmp <= {64{1'b1}};
      end else if (wrEn && (regAddr == ADDR_MTIMECMP_LO)) begin
         mtimecmp <= {mtimecmp[63:32], wrData};
      end else if (wrEn && (regAddr == ADDR_MTIMECMP_HI)) begin
         mtimecmp <= {wrData, mtimecmp[31:0]};
      end
   end

   // Interrupt is a pure level computed from the current register values.
   always_ff @(posedge clk) begin
      if (rst) begin
         reqTimerInterrupt <= 1'b0;
      end else begin
         reqTimerInterrupt <= (mtime >= mtimecmp);
      end
   end

   // Reads sample pre-edge register values, so a same-cycle write is seen
   // only by later reads. A LO read latches the HI half of the same
   // snapshot so a following HI read yields a consistent 64-bit value.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdData    <= '0;
         rdValid   <= 1'b0;
         shadow_hi <= 32'd0;
      end else begin
         rdValid <= rdEn;
         if (rdEn) begin
            case (regAddr)
               ADDR_MTIME_LO: begin
                  rdData    <= mtime[31:0];
                  shadow_hi <= mtime[63:32];
               end
               ADDR_MTIME_HI:    rdData <= shadow_hi;
               ADDR_MTIMECMP_LO: rdData <= mtimecmp[31:0];
               ADDR_MTIMECMP_HI: rdData <= mtimecmp[63:32];
               default:          rdData <= rdData;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_machine_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_machine_timer_unit
//  Purpose  : Directed self-checking bench for machine_timer_unit. One
//             instance uses PRESCALE_DIV = 1, a second uses PRESCALE_DIV = 4
//             with its own reset and bus inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_machine_timer_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrEn, rdEn;
   logic [1:0]  regAddr;
   logic [31:0] wrData;
   logic [31:0] rdData;
   logic        rdValid, irq;
   logic [63:0] mtimeOut;

   logic        rst4;
   logic        wrEn4, rdEn4;
   logic [1:0]  regAddr4;
   logic [31:0] wrData4;
   logic [31:0] rdData4;
   logic        rdValid4, irq4;
   logic [63:0] mtimeOut4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   machine_timer_unit #(.PRESCALE_DIV(1), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .regAddr(regAddr),
      .wrData(wrData), .rdData(rdData), .rdValid(rdValid),
      .reqTimerInterrupt(irq), .mtimeOut(mtimeOut)
   );

   machine_timer_unit #(.PRESCALE_DIV(4), .DATA_WIDTH(32)) dut4 (
      .clk(clk), .rst(rst4), .wrEn(wrEn4), .rdEn(rdEn4), .regAddr(regAddr4),
      .wrData(wrData4), .rdData(rdData4), .rdValid(rdValid4),
      .reqTimerInterrupt(irq4), .mtimeOut(mtimeOut4)
   );

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus(input logic w, input logic r, input logic [1:0] a,
                      input logic [31:0] d);
      wrEn = w; rdEn = r; regAddr = a; wrData = d;
   endtask

   task automatic test_reset;
      rst = 1'b1; rst4 = 1'b1;
      bus(1'b0, 1'b0, 2'd0, 32'd0);
      wrEn4 = 1'b0; rdEn4 = 1'b0; regAddr4 = 2'd0; wrData4 = 32'd0;
      step(2);
      checks++;
      if (mtimeOut !== 64'd0) begin
         failures++; $display("FAIL reset_mtime: got %h expected 0", mtimeOut);
      end
      checks++;
      if (irq !== 1'b0 || rdValid !== 1'b0 || rdData !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: irq=%b rdValid=%b rdData=%h expected 0/0/0",
                  irq, rdValid, rdData);
      end
      checks++;
      if (mtimeOut4 !== 64'd0 || irq4 !== 1'b0 || rdValid4 !== 1'b0) begin
         failures++;
         $display("FAIL reset_div4: mtime=%h irq=%b rdValid=%b expected 0/0/0",
                  mtimeOut4, irq4, rdValid4);
      end
   endtask

   task automatic test_count;
      rst = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++;
         if (irq !== 1'b0 || rdValid !== 1'b0) begin
            failures++;
            $display("FAIL count_idle cycle %0d: irq=%b rdValid=%b expected 0/0",
                     i, irq, rdValid);
         end
      end
      checks++;
      if (mtimeOut !== 64'd10) begin
         failures++; $display("FAIL count_10: got %0d expected 10", mtimeOut);
      end
   endtask

   task automatic test_compare;
      bus(1'b1, 1'b0, 2'd3, 32'd0);  step();   // mtime 11
      bus(1'b1, 1'b0, 2'd2, 32'd20); step();   // mtime 12, cmp 20
      bus(1'b0, 1'b0, 2'd0, 32'd0);
      step(8);                                 // mtime 20
      checks++;
      if (mtimeOut !== 64'd20 || irq !== 1'b0) begin
         failures++;
         $display("FAIL cmp_before: mtime=%0d irq=%b expected 20/0", mtimeOut, irq);
      end
      step();
      checks++;
      if (irq !== 1'b1) begin
         failures++; $display("FAIL cmp_rise: irq=%b expected 1", irq);
      end
      bus(1'b1, 1'b0, 2'd2, 32'd100); step();  // compare still used old cmp
      checks++;
      if (irq !== 1'b1) begin
         failures++; $display("FAIL cmp_write_cycle: irq=%b expected 1", irq);
      end
      bus(1'b0, 1'b0, 2'd0, 32'd0); step();
      checks++;
      if (irq !== 1'b0) begin
         failures++; $display("FAIL cmp_fall: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_wrap;
      bus(1'b1, 1'b0, 2'd2, 32'd5);          step();
      bus(1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF);  step();
      bus(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFE);  step();
      bus(1'b0, 1'b0, 2'd0, 32'd0);
      checks++;
      if (mtimeOut !== 64'hFFFF_FFFF_FFFF_FFFE || irq !== 1'b1) begin
         failures++;
         $display("FAIL wrap_load: mtime=%h irq=%b expected FFFFFFFFFFFFFFFE/1",
                  mtimeOut, irq);
      end
      step(2);
      checks++;
      if (mtimeOut !== 64'd0 || irq !== 1'b1) begin
         failures++;
         $display("FAIL wrap_zero: mtime=%h irq=%b expected 0/1", mtimeOut, irq);
      end
      step();
      checks++;
      if (irq !== 1'b0) begin
         failures++; $display("FAIL wrap_fall: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_snapshot;
      bus(1'b1, 1'b0, 2'd1, 32'd0);          step();
      bus(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF);  step();
      checks++;
      if (mtimeOut !== 64'h0000_0000_FFFF_FFFF) begin
         failures++;
         $display("FAIL snap_load: got %h expected 00000000FFFFFFFF", mtimeOut);
      end
      bus(1'b0, 1'b1, 2'd0, 32'd0); step();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'hFFFF_FFFF ||
          mtimeOut !== 64'h0000_0001_0000_0000) begin
         failures++;
         $display("FAIL snap_lo: rdValid=%b rdData=%h mtime=%h expected 1/FFFFFFFF/100000000",
                  rdValid, rdData, mtimeOut);
      end
      bus(1'b0, 1'b1, 2'd1, 32'd0); step();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'd0 || mtimeOut[63:32] !== 32'd1) begin
         failures++;
         $display("FAIL snap_hi: rdValid=%b rdData=%h mtime_hi=%h expected 1/0/1",
                  rdValid, rdData, mtimeOut[63:32]);
      end
      bus(1'b0, 1'b0, 2'd0, 32'd0); step();
      checks++;
      if (rdValid !== 1'b0 || rdData !== 32'd0) begin
         failures++;
         $display("FAIL snap_hold: rdValid=%b rdData=%h expected 0/0", rdValid, rdData);
      end
   endtask

   task automatic test_prescale;
      rst4 = 1'b1; step(); rst4 = 1'b0;
      step(3);
      checks++;
      if (mtimeOut4 !== 64'd0) begin
         failures++; $display("FAIL div4_early: got %0d expected 0", mtimeOut4);
      end
      step();
      checks++;
      if (mtimeOut4 !== 64'd1) begin
         failures++; $display("FAIL div4_first: got %0d expected 1", mtimeOut4);
      end
      step(3);                                 // next edge is a tick
      wrEn4 = 1'b1; regAddr4 = 2'd0; wrData4 = 32'h1234;
      step();
      wrEn4 = 1'b0;
      checks++;
      if (mtimeOut4 !== 64'h1234) begin
         failures++; $display("FAIL div4_write: got %h expected 1234", mtimeOut4);
      end
      step(3);
      checks++;
      if (mtimeOut4 !== 64'h1234) begin
         failures++; $display("FAIL div4_hold: got %h expected 1234", mtimeOut4);
      end
      step();
      checks++;
      if (mtimeOut4 !== 64'h1235) begin
         failures++; $display("FAIL div4_next: got %h expected 1235", mtimeOut4);
      end
   endtask

   task automatic test_back_to_back;
      bus(1'b1, 1'b1, 2'd2, 32'd7); step();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'd5) begin
         failures++;
         $display("FAIL rbw_old: rdValid=%b rdData=%0d expected 1/5", rdValid, rdData);
      end
      bus(1'b0, 1'b1, 2'd2, 32'd0); step();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'd7) begin
         failures++;
         $display("FAIL rbw_new: rdValid=%b rdData=%0d expected 1/7", rdValid, rdData);
      end
      bus(1'b0, 1'b1, 2'd0, 32'd0); rst = 1'b1; step();
      checks++;
      if (rdValid !== 1'b0 || mtimeOut !== 64'd0 || irq !== 1'b0 || rdData !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset: rdValid=%b mtime=%h irq=%b rdData=%h expected 0/0/0/0",
                  rdValid, mtimeOut, irq, rdData);
      end
      rst = 1'b0;
      bus(1'b0, 1'b1, 2'd3, 32'd0); step();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL reset_cmp_hi: rdValid=%b rdData=%h expected 1/FFFFFFFF",
                  rdValid, rdData);
      end
      bus(1'b0, 1'b1, 2'd2, 32'd0); step();
      checks++;
      if (rdValid !== 1'b1 || rdData !== 32'hFFFF_FFFF || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_cmp_lo: rdValid=%b rdData=%h irq=%b expected 1/FFFFFFFF/0",
                  rdValid, rdData, irq);
      end
      bus(1'b0, 1'b0, 2'd0, 32'd0); step();
   endtask

   initial begin
      test_reset();
      test_count();
      test_compare();
      test_wrap();
      test_snapshot();
      test_prescale();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
